// File: rtl/sysclk_bitcmd_req_if.sv
// Bitcommand request bus between phase/request sources and the request generator.
// The slave modport is the generator side; the master modport drives phase, SYNC and requests.
interface sysclk_bitcmd_req_if #(
  parameter int NUM_CMD = 4
) ();
  logic               sysclk_phase_i;
  logic               sysclk_sync_i;
  logic [NUM_CMD-1:0] req_i;
  logic [NUM_CMD-1:0] cmd_en_i;
  logic [NUM_CMD-1:0] overrun_clr_i;
  logic [NUM_CMD-1:0] bitcommand_o;
  logic [NUM_CMD-1:0] issued_o;
  logic [NUM_CMD-1:0] pending_o;
  logic [NUM_CMD-1:0] overrun_o;

  modport slave (
    input  sysclk_phase_i,
    input  sysclk_sync_i,
    input  req_i,
    input  cmd_en_i,
    input  overrun_clr_i,
    output bitcommand_o,
    output issued_o,
    output pending_o,
    output overrun_o
  );

  modport master (
    output sysclk_phase_i,
    output sysclk_sync_i,
    output req_i,
    output cmd_en_i,
    output overrun_clr_i,
    input  bitcommand_o,
    input  issued_o,
    input  pending_o,
    input  overrun_o
  );
endinterface

// File: rtl/sysclk_bitcmd_req.sv
// Multi-channel bitcommand request generator: async requests are synchronised, held pending and
// issued as one-phase-long bitcommand bits at the next qualifying phase boundary.
module sysclk_bitcmd_req #(
  parameter int                 NUM_CMD    = 4,
  parameter logic [NUM_CMD-1:0] SYNC_GATED = NUM_CMD'(4'b0001),
  parameter logic [NUM_CMD-1:0] REQ_TOGGLE = '0
) (
  input  logic                      sysclk_i,
  input  logic                      sysclk_rstn_i,
  sysclk_bitcmd_req_if.slave        bus
);

  localparam logic [1:0] ARM_DONE = 2'd3;

  function automatic logic [1:0] arm_step(input logic [1:0] cnt);
    return (cnt == ARM_DONE) ? cnt : cnt + 2'd1;
  endfunction

  (* ASYNC_REG = "TRUE", CUSTOM_CC_DST = "SYSCLK" *)
  logic [NUM_CMD-1:0] sync0_q;
  (* ASYNC_REG = "TRUE", CUSTOM_CC_DST = "SYSCLK" *)
  logic [NUM_CMD-1:0] sync1_q;
  logic [NUM_CMD-1:0] rereg_q;

  logic [1:0]         arm_q, arm_d;
  logic               armed;
  logic               phase_d_q;

  logic [NUM_CMD-1:0] event_w;
  logic [NUM_CMD-1:0] sync_ok_w;
  logic [NUM_CMD-1:0] issue_w;

  logic [NUM_CMD-1:0] pending_q, pending_d;
  logic [NUM_CMD-1:0] overrun_q, overrun_d;
  logic [NUM_CMD-1:0] bitcmd_q, bitcmd_d;
  logic [NUM_CMD-1:0] issued_q, issued_d;

  // Stage 0/1: two-flop synchroniser, then a re-register that provides the edge reference
  always_ff @(posedge sysclk_i) begin
    if (!sysclk_rstn_i) begin
      sync0_q <= '0;
      sync1_q <= '0;
      rereg_q <= '0;
    end else begin
      sync0_q <= bus.req_i;
      sync1_q <= sync0_q;
      rereg_q <= sync1_q;
    end
  end

  // Edges are ignored until the synchroniser has flushed post-reset levels.
  assign arm_d = arm_step(arm_q);
  assign armed = (arm_q == ARM_DONE);

  always_comb begin
    event_w = '0;
    for (int k = 0; k < NUM_CMD; k++) begin
      if (REQ_TOGGLE[k]) begin
        event_w[k] = armed & (sync1_q[k] ^ rereg_q[k]);
      end else begin
        event_w[k] = armed & sync1_q[k] & ~rereg_q[k];
      end
    end
  end

  // Stage 2: issue decision on the cycle after the phase pulse, where SYNC is valid
  always_comb begin
    sync_ok_w = ~SYNC_GATED | {NUM_CMD{bus.sysclk_sync_i}};
    issue_w   = {NUM_CMD{phase_d_q}} & pending_q & bus.cmd_en_i & sync_ok_w;

    pending_d = event_w | (pending_q & ~issue_w);
    overrun_d = (event_w & pending_q & ~issue_w) | (overrun_q & ~bus.overrun_clr_i);

    bitcmd_d  = phase_d_q ? issue_w : bitcmd_q;
    issued_d  = issue_w;
  end

  always_ff @(posedge sysclk_i) begin
    if (!sysclk_rstn_i) begin
      arm_q     <= '0;
      phase_d_q <= 1'b0;
      pending_q <= '0;
      overrun_q <= '0;
      bitcmd_q  <= '0;
      issued_q  <= '0;
    end else begin
      arm_q     <= arm_d;
      phase_d_q <= bus.sysclk_phase_i;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      bitcmd_q  <= bitcmd_d;
      issued_q  <= issued_d;
    end
  end

  assign bus.bitcommand_o = bitcmd_q;
  assign bus.issued_o     = issued_q;
  assign bus.pending_o    = pending_q;
  assign bus.overrun_o    = overrun_q;

  // An issue pulse always marks a cycle where the bit it issued is high.
  issued_within_bitcmd: assert property (
    @(posedge sysclk_i) disable iff (!sysclk_rstn_i)
      (issued_q & ~bitcmd_q) == '0
  );

endmodule

// File: tb/tb_sysclk_bitcmd_req.sv
// Directed bench for sysclk_bitcmd_req: table of 48-cycle scenarios plus hand-written sequences
// for reset-release masking, overrun clear and reset during an active bitcommand.
module tb_sysclk_bitcmd_req;
  localparam int NUM_CMD = 4;
  localparam int NONE    = 1000;
  localparam int NCYC    = 48;
  localparam int NV      = 7;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sysclk_bitcmd_req_if #(.NUM_CMD(NUM_CMD)) bus ();

  sysclk_bitcmd_req #(
    .NUM_CMD   (NUM_CMD),
    .SYNC_GATED(4'b0001),
    .REQ_TOGGLE(4'b1000)
  ) dut (
    .sysclk_i     (clk),
    .sysclk_rstn_i(rstn),
    .bus          (bus)
  );

  typedef struct {
    logic [3:0]      mask;
    int              ta, tb, tc;
    logic [3:0]      en_lo;
    int              en_at;
    logic [3:0]      sync;
    logic [3:0]      exp_pend;
    logic [3:0][3:0] exp_bc;
    logic [15:0]     exp_iss;
    logic [3:0]      exp_ovr;
    int              exp_hi;
  } vec_t;

  vec_t vecs [NV];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v, input int n);
    logic [3:0] lvl;
    int         idx;
    logic       s;
    rstn = (n >= 3);
    bus.sysclk_phase_i = (n % 8 == 0);
    if (n < 10) begin
      bus.sysclk_sync_i = 1'b0;
    end else begin
      idx = (n - 10) / 8;
      if (idx > 3) idx = 3;
      s = v.sync[idx];
      bus.sysclk_sync_i = (n % 8 == 1) ? s : ~s;
    end
    lvl = '0;
    if (n >= v.ta) lvl ^= v.mask;
    if (n >= v.tb) lvl ^= v.mask;
    if (n >= v.tc) lvl ^= v.mask;
    bus.req_i         = lvl;
    bus.cmd_en_i      = (n < v.en_at) ? v.en_lo : 4'hF;
    bus.overrun_clr_i = '0;
  endtask

  task automatic tick(input logic ph);
    bus.sysclk_phase_i = ph;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus.sysclk_phase_i = 1'b0;
    bus.sysclk_sync_i  = 1'b0;
    bus.req_i          = '0;
    bus.cmd_en_i       = '0;
    bus.overrun_clr_i  = '0;

    // basic issue on channel 1
    vecs[0] = '{mask:4'b0010, ta:12, tb:NONE, tc:NONE, en_lo:4'hF, en_at:0, sync:4'hF,
                exp_pend:4'b0010, exp_bc:{4'h0, 4'h0, 4'h0, 4'h2}, exp_iss:16'h0010,
                exp_ovr:4'h0, exp_hi:8};
    // gated ch0 waits for SYNC=1 at the second boundary, ungated ch2 goes at the first
    vecs[1] = '{mask:4'b0101, ta:12, tb:NONE, tc:NONE, en_lo:4'hF, en_at:0, sync:4'b1110,
                exp_pend:4'b0101, exp_bc:{4'h0, 4'h0, 4'h1, 4'h4}, exp_iss:16'h0101,
                exp_ovr:4'h0, exp_hi:16};
    // two ch2 pulses before the boundary: overrun, single issue
    vecs[2] = '{mask:4'b0100, ta:12, tb:13, tc:14, en_lo:4'hF, en_at:0, sync:4'hF,
                exp_pend:4'b0100, exp_bc:{4'h0, 4'h0, 4'h0, 4'h4}, exp_iss:16'h0100,
                exp_ovr:4'h4, exp_hi:8};
    // second ch2 event lands on the issue cycle: set wins, 16-cycle bit, no overrun
    vecs[3] = '{mask:4'b0100, ta:12, tb:14, tc:15, en_lo:4'hF, en_at:0, sync:4'hF,
                exp_pend:4'b0100, exp_bc:{4'h0, 4'h0, 4'h4, 4'h4}, exp_iss:16'h0200,
                exp_ovr:4'h0, exp_hi:16};
    // rise then fall: toggle ch3 issues twice, level ch1 once
    vecs[4] = '{mask:4'b1010, ta:12, tb:20, tc:NONE, en_lo:4'hF, en_at:0, sync:4'hF,
                exp_pend:4'b1010, exp_bc:{4'h0, 4'h0, 4'h8, 4'hA}, exp_iss:16'h2010,
                exp_ovr:4'h0, exp_hi:24};
    // ch1 disabled across three boundaries, issues after re-enable
    vecs[5] = '{mask:4'b0010, ta:12, tb:NONE, tc:NONE, en_lo:4'b1101, en_at:34, sync:4'hF,
                exp_pend:4'b0010, exp_bc:{4'h2, 4'h0, 4'h0, 4'h0}, exp_iss:16'h0010,
                exp_ovr:4'h0, exp_hi:7};
    // gated ch0 with SYNC low for two boundaries
    vecs[6] = '{mask:4'b0001, ta:12, tb:NONE, tc:NONE, en_lo:4'hF, en_at:0, sync:4'b1100,
                exp_pend:4'b0001, exp_bc:{4'h0, 4'h1, 4'h0, 4'h0}, exp_iss:16'h0001,
                exp_ovr:4'h0, exp_hi:8};

    for (int vi = 0; vi < NV; vi++) begin
      int          cnt [4];
      int          hi;
      bit          bad;
      logic [15:0] iss_pk;
      for (int k = 0; k < 4; k++) cnt[k] = 0;
      hi  = 0;
      bad = 1'b0;
      for (int n = 0; n < NCYC; n++) begin
        drive_vec(vecs[vi], n);
        @(posedge clk);
        #1;
        if (n == 2)
          check($sformatf("v%0d_reset", vi),
                {bus.bitcommand_o, bus.issued_o, bus.pending_o, bus.overrun_o}, 32'h0);
        if (n == 16)
          check($sformatf("v%0d_pending", vi), bus.pending_o, vecs[vi].exp_pend);
        if (n == 20 || n == 28 || n == 36 || n == 44)
          check($sformatf("v%0d_bc_w%0d", vi, (n - 20) / 8), bus.bitcommand_o,
                vecs[vi].exp_bc[(n - 20) / 8]);
        hi += $countones(bus.bitcommand_o);
        for (int k = 0; k < 4; k++) cnt[k] += int'(bus.issued_o[k]);
        if ((bus.issued_o & ~bus.bitcommand_o) != 4'h0) bad = 1'b1;
      end
      iss_pk = {cnt[3][3:0], cnt[2][3:0], cnt[1][3:0], cnt[0][3:0]};
      check($sformatf("v%0d_issue_counts", vi), iss_pk, vecs[vi].exp_iss);
      check($sformatf("v%0d_overrun", vi), bus.overrun_o, vecs[vi].exp_ovr);
      check($sformatf("v%0d_high_cycles", vi), hi, vecs[vi].exp_hi);
      check($sformatf("v%0d_issued_outside_bit", vi), 32'(bad), 32'h0);
    end

    // requests held high through reset release must not generate events
    begin
      logic [3:0] seen;
      seen = '0;
      rstn = 1'b0;
      bus.req_i = 4'b1010;
      bus.cmd_en_i = 4'hF;
      bus.overrun_clr_i = '0;
      bus.sysclk_sync_i = 1'b1;
      repeat (3) tick(1'b0);
      rstn = 1'b1;
      for (int i = 0; i < 24; i++) begin
        tick(i % 8 == 0);
        seen |= bus.pending_o | bus.bitcommand_o;
      end
      check("held_req_no_event", seen, 4'h0);
    end

    // overrun on ch2, clear, issue, then reset while the bit is high
    bus.req_i = 4'b1110; tick(1'b0);
    bus.req_i = 4'b1010; tick(1'b0);
    bus.req_i = 4'b1110;
    repeat (4) tick(1'b0);
    check("ovr_seq_pending", bus.pending_o, 4'b0100);
    check("ovr_seq_overrun", bus.overrun_o, 4'b0100);
    bus.overrun_clr_i = 4'b0100;
    tick(1'b0);
    bus.overrun_clr_i = '0;
    check("ovr_clear", {bus.overrun_o, bus.pending_o}, {4'h0, 4'b0100});
    tick(1'b1);
    tick(1'b0);
    check("post_clr_issue", {bus.bitcommand_o, bus.issued_o, bus.pending_o},
          {4'b0100, 4'b0100, 4'h0});
    tick(1'b0);
    check("issued_one_cycle", {bus.bitcommand_o, bus.issued_o}, {4'b0100, 4'h0});
    rstn = 1'b0;
    tick(1'b0);
    check("reset_mid_bitcmd",
          {bus.bitcommand_o, bus.issued_o, bus.pending_o, bus.overrun_o}, 32'h0);
    rstn = 1'b1;
    repeat (2) tick(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
